// File: rtl/seq1010_detector_if.sv
// seq1010_detector_if: serial bit in, match flag out; match_cnt is present only when SEQ1010_COUNT_EN is defined
`ifdef SEQ1010_COUNT_EN
interface seq1010_detector_if #(parameter int CNT_W = 8);
  logic in;
  logic out;
  logic [CNT_W-1:0] match_cnt;
  modport master (output in, input out, match_cnt);
  modport slave (input in, output out, match_cnt);
endinterface
`else
interface seq1010_detector_if;
  logic in;
  logic out;
  modport master (output in, input out);
  modport slave (input in, output out);
endinterface
`endif

// File: rtl/seq1010_detector.sv
// seq1010_detector: Moore FSM pulsing out while the last sampled bits form 1010; SEQ1010_COUNT_EN adds a wrapping match counter
module seq1010_detector #(
  parameter int OVERLAP = 1
`ifdef SEQ1010_COUNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input logic clk,
  input logic reset,
  seq1010_detector_if.slave bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_1    = 3'd1;
  localparam logic [2:0] S_10   = 3'd2;
  localparam logic [2:0] S_101  = 3'd3;
  localparam logic [2:0] S_1010 = 3'd4;
  logic [2:0] r_state;
  logic [2:0] w_next;
  always_comb
    case (r_state)
      S_IDLE:  w_next = bus.in ? S_1 : S_IDLE;
      S_1:     w_next = bus.in ? S_1 : S_10;
      S_10:    w_next = bus.in ? S_101 : S_IDLE;
      S_101:   w_next = bus.in ? S_1 : S_1010;
      S_1010:  w_next = bus.in ? ((OVERLAP != 0) ? S_101 : S_1) : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= S_IDLE;
    else r_state <= w_next;
  assign bus.out = (r_state == S_1010);
`ifdef SEQ1010_COUNT_EN
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_cnt <= '0;
    else if (w_next == S_1010) r_cnt <= r_cnt + 1'b1;
  assign bus.match_cnt = r_cnt;
`endif
endmodule

// File: tb/tb_seq1010_detector.sv
// tb_seq1010_detector: directed table plus random stream against a bit-history model, OVERLAP=1 and OVERLAP=0 side by side
module tb_seq1010_detector;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;

`ifdef SEQ1010_COUNT_EN
  seq1010_detector_if #(.CNT_W(8)) b1 ();
  seq1010_detector_if #(.CNT_W(2)) b0 ();
  seq1010_detector #(.OVERLAP(1), .CNT_W(8)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  seq1010_detector #(.OVERLAP(0), .CNT_W(2)) dut0 (.clk(clk), .reset(reset), .bus(b0));
`else
  seq1010_detector_if b1 ();
  seq1010_detector_if b0 ();
  seq1010_detector #(.OVERLAP(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  seq1010_detector #(.OVERLAP(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
`endif

  typedef struct {
    bit rst;
    bit b;
    bit e1;
    bit e0;
  } vec_t;
  vec_t tv[$];

  // Model: the last four bits seen since reset (overlap) or since the last match (no overlap)
  bit [3:0] h1, h0;
  int n1, n0, m1, m0;
  bit p1, p0;

  function automatic void add(bit r, bit b, bit e1, bit e0);
    vec_t v;
    v.rst = r;
    v.b = b;
    v.e1 = e1;
    v.e0 = e0;
    tv.push_back(v);
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    h1 = '0; h0 = '0; n1 = 0; n0 = 0; m1 = 0; m0 = 0; p1 = 0; p0 = 0;
  endtask

  task automatic check_model();
    check("out_ovl", int'(b1.out), int'(p1));
    check("out_novl", int'(b0.out), int'(p0));
`ifdef SEQ1010_COUNT_EN
    check("cnt_ovl", int'(b1.match_cnt), m1 % 256);
    check("cnt_novl", int'(b0.match_cnt), m0 % 4);
`endif
  endtask

  task automatic step(bit b);
    b1.in = b;
    b0.in = b;
    @(posedge clk);
    h1 = {h1[2:0], b};
    h0 = {h0[2:0], b};
    n1++;
    n0++;
    p1 = (n1 >= 4) && (h1 == 4'b1010);
    p0 = (n0 >= 4) && (h0 == 4'b1010);
    if (p1) m1++;
    if (p0) begin
      m0++;
      n0 = 0;
    end
    #1;
    check_model();
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    model_reset();
    #1;
    check_model();
    #1;
    reset = 1'b1;
  endtask

  initial begin
    b1.in = 1'b0;
    b0.in = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      b1.in = 1'($urandom_range(0, 1));
      b0.in = b1.in;
      @(posedge clk);
      #1;
      check_model();
    end
    reset = 1'b1;

    add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 1, 0, 0); add(0, 0, 1, 1);
    add(0, 1, 0, 0); add(0, 0, 1, 0); add(0, 1, 0, 0); add(0, 0, 1, 1);
    add(1, 0, 0, 0);
    add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 0, 0, 0); add(0, 1, 0, 0);
    add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 1, 0, 0); add(0, 0, 1, 1);
    add(0, 0, 0, 0); add(0, 1, 0, 0); add(0, 0, 0, 0);
    add(1, 0, 0, 0);
    add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 1, 0, 0);
    add(1, 0, 0, 0);
    add(0, 0, 0, 0); add(0, 1, 0, 0); add(0, 0, 0, 0);
    add(0, 1, 0, 0); add(0, 0, 1, 1);

    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].rst) pulse_reset();
      else begin
        step(tv[i].b);
        check($sformatf("tv%0d_ovl", i), int'(b1.out), int'(tv[i].e1));
        check($sformatf("tv%0d_novl", i), int'(b0.out), int'(tv[i].e0));
      end
    end

    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      step(1'b1); step(1'b0); step(1'b1); step(1'b0);
    end
`ifdef SEQ1010_COUNT_EN
    check("wrap_novl", int'(b0.match_cnt), 1);
    check("count_ovl", int'(b1.match_cnt), 9);
`endif

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) pulse_reset();
      else step(1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
